// File: rtl/rf_pkg.sv
// Shared types, defaults and the port-priority helper for the multi-port register file.
package rf_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int MAX_WR     = 8;

   typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
   typedef logic [DATA_W_DEF-1:0] reg_data_t;

   // One-hot of the highest-index requester: the later write port always wins.
   function automatic logic [MAX_WR-1:0] onehot_priority(input logic [MAX_WR-1:0] req);
      logic [MAX_WR-1:0] sel;
      sel = '0;
      for (int unsigned i = 0; i < MAX_WR; i++) begin
         if (req[i]) begin
            sel    = '0;
            sel[i] = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-producer scoreboard: one bit per register, set at issue, cleared at writeback,
// with a running count kept alongside the vector.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     flush,
   input  logic                     issue_valid,
   input  logic [ADDR_W-1:0]        issue_addr,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*ADDR_W-1:0] waddr,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD-1:0]        rd_pending,
   output logic [ADDR_W:0]          pend_cnt
);

   localparam int NREG = 2**ADDR_W;
   localparam int CW   = ADDR_W + 1;

   logic [NREG-1:0] pending;
   logic [NREG-1:0] pend_next;
   logic [CW-1:0]   n_set;
   logic [CW-1:0]   n_clr;
   logic [CW-1:0]   cnt_next;

   always_comb begin
      pend_next = pending;
      if (flush) begin
         pend_next = '0;
      end else begin
         for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (we[i] && (waddr[i*ADDR_W +: ADDR_W] != '0))
               pend_next[waddr[i*ADDR_W +: ADDR_W]] = 1'b0;
         end
         // Applied after the clears so a new producer overrides a same-cycle writeback.
         if (issue_valid && (issue_addr != '0))
            pend_next[issue_addr] = 1'b1;
      end
   end

   always_comb begin
      n_set = '0;
      n_clr = '0;
      for (int unsigned r = 1; r < NREG; r++) begin
         n_set = n_set + CW'(~pending[r] & pend_next[r]);
         n_clr = n_clr + CW'(pending[r] & ~pend_next[r]);
      end
      cnt_next = pend_cnt + n_set - n_clr;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pending  <= '0;
         pend_cnt <= '0;
      end else begin
         pending  <= pend_next;
         pend_cnt <= cnt_next;
      end
   end

   always_comb begin
      rd_pending = '0;
      for (int unsigned k = 0; k < NUM_RD; k++)
         rd_pending[k] = pending[raddr[k*ADDR_W +: ADDR_W]];
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with r0 hard-wired to zero, optional write-to-read
// bypass, and an integrated operand-ready scoreboard.
module regfile_mp
   import rf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2,
   parameter bit BYPASS = 1'b1
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD*DATA_W-1:0] rdata,
   output logic [NUM_RD-1:0]        rready,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*ADDR_W-1:0] waddr,
   input  logic [NUM_WR*DATA_W-1:0] wdata,
   input  logic                     issue_valid,
   input  logic [ADDR_W-1:0]        issue_addr,
   input  logic                     flush,
   output logic [ADDR_W:0]          pend_cnt
);

   localparam int NREG = 2**ADDR_W;

   logic [DATA_W-1:0] rf [NREG];
   logic [MAX_WR-1:0] wr_same [NUM_WR];
   logic [MAX_WR-1:0] wr_sel  [NUM_WR];
   logic [NUM_WR-1:0] wr_win;
   logic [ADDR_W-1:0] rd_addr  [NUM_RD];
   logic [MAX_WR-1:0] rd_match [NUM_RD];
   logic [MAX_WR-1:0] rd_sel   [NUM_RD];
   logic [NUM_RD-1:0] rd_hit;
   logic [NUM_RD-1:0] rd_pending;

   rf_scoreboard #(
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD),
      .NUM_WR (NUM_WR)
   ) u_scoreboard (
      .clk         (clk),
      .resetn      (resetn),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_addr  (issue_addr),
      .we          (we),
      .waddr       (waddr),
      .raddr       (raddr),
      .rd_pending  (rd_pending),
      .pend_cnt    (pend_cnt)
   );

   // A port commits only if no higher-index port targets the same register this cycle.
   always_comb begin
      wr_win = '0;
      for (int unsigned i = 0; i < NUM_WR; i++) begin
         wr_same[i] = '0;
         for (int unsigned j = 0; j < NUM_WR; j++)
            wr_same[i][j] = we[j] && (waddr[j*ADDR_W +: ADDR_W] == waddr[i*ADDR_W +: ADDR_W]);
         wr_sel[i] = onehot_priority(wr_same[i]);
         wr_win[i] = we[i] && (waddr[i*ADDR_W +: ADDR_W] != '0) && wr_sel[i][i];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned r = 0; r < NREG; r++)
            rf[r] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (wr_win[i])
               rf[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      rdata  = '0;
      rd_hit = '0;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         rd_addr[k]  = raddr[k*ADDR_W +: ADDR_W];
         rd_match[k] = '0;
         for (int unsigned i = 0; i < NUM_WR; i++)
            rd_match[k][i] = we[i] && (waddr[i*ADDR_W +: ADDR_W] == rd_addr[k]);
         rd_sel[k] = onehot_priority(rd_match[k]);
         rd_hit[k] = BYPASS && (rd_addr[k] != '0) && (|rd_match[k]);
         if (rd_addr[k] != '0) begin
            rdata[k*DATA_W +: DATA_W] = rf[rd_addr[k]];
            for (int unsigned i = 0; i < NUM_WR; i++) begin
               if (rd_hit[k] && rd_sel[k][i])
                  rdata[k*DATA_W +: DATA_W] = wdata[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_comb begin
      rready = '0;
      for (int unsigned k = 0; k < NUM_RD; k++)
         rready[k] = (rd_addr[k] == '0) || !rd_pending[k] || rd_hit[k];
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass and no-bypass builds driven in lockstep and compared
// against a behavioural register/pending model, plus directed vectors and reset cases.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic [9:0]  raddr = '0;
   logic [1:0]  we = '0;
   logic [9:0]  waddr = '0;
   logic [63:0] wdata = '0;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_addr = '0;
   logic        flush = 1'b0;

   logic [63:0] rdata_b, rdata_n;
   logic [1:0]  rready_b, rready_n;
   logic [5:0]  cnt_b, cnt_n;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_rf [32];
   bit          m_pend [32];

   always #5 clk = ~clk;

   regfile_mp #(.BYPASS(1'b1)) dut_b (
      .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata_b), .rready(rready_b),
      .we(we), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid),
      .issue_addr(issue_addr), .flush(flush), .pend_cnt(cnt_b)
   );

   regfile_mp #(.BYPASS(1'b0)) dut_n (
      .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata_n), .rready(rready_n),
      .we(we), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid),
      .issue_addr(issue_addr), .flush(flush), .pend_cnt(cnt_n)
   );

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0, wa1;
      logic [31:0] wd0, wd1;
      logic [4:0]  ra0, ra1;
      logic        iv;
      logic [4:0]  ia;
      logic        fl;
      logic [31:0] rd0_b, rd0_n;
      logic [1:0]  rdy_b, rdy_n;
      logic [5:0]  cnt;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         m_rf[r]   = '0;
         m_pend[r] = 1'b0;
      end
   endtask

   task automatic model_update();
      if (!resetn) begin
         model_reset();
      end else begin
         for (int i = 0; i < 2; i++)
            if (we[i] && waddr[i*5 +: 5] != 5'd0) m_rf[waddr[i*5 +: 5]] = wdata[i*32 +: 32];
         if (flush) begin
            for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
         end else begin
            for (int i = 0; i < 2; i++)
               if (we[i] && waddr[i*5 +: 5] != 5'd0) m_pend[waddr[i*5 +: 5]] = 1'b0;
            if (issue_valid && issue_addr != 5'd0) m_pend[issue_addr] = 1'b1;
         end
      end
   endtask

   function automatic bit wr_match(input logic [4:0] a);
      bit hit = 1'b0;
      for (int i = 0; i < 2; i++)
         if (we[i] && waddr[i*5 +: 5] == a) hit = 1'b1;
      return hit;
   endfunction

   function automatic logic [31:0] exp_rdata(input int k, input bit byp);
      logic [4:0]  a;
      logic [31:0] v;
      a = raddr[k*5 +: 5];
      if (a == 5'd0) return '0;
      v = m_rf[a];
      if (byp)
         for (int i = 0; i < 2; i++)
            if (we[i] && waddr[i*5 +: 5] == a) v = wdata[i*32 +: 32];
      return v;
   endfunction

   function automatic logic exp_rready(input int k, input bit byp);
      logic [4:0] a;
      a = raddr[k*5 +: 5];
      return (a == 5'd0) || !m_pend[a] || (byp && wr_match(a));
   endfunction

   function automatic logic [5:0] m_count();
      int n = 0;
      for (int r = 0; r < 32; r++) n += int'(m_pend[r]);
      return 6'(n);
   endfunction

   task automatic check_outputs();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("byp_rdata%0d", k), rdata_b[k*32 +: 32], exp_rdata(k, 1'b1));
         check($sformatf("nob_rdata%0d", k), rdata_n[k*32 +: 32], exp_rdata(k, 1'b0));
         check($sformatf("byp_rready%0d", k), rready_b[k], exp_rready(k, 1'b1));
         check($sformatf("nob_rready%0d", k), rready_n[k], exp_rready(k, 1'b0));
      end
      check("byp_pend_cnt", cnt_b, m_count());
      check("nob_pend_cnt", cnt_n, m_count());
   endtask

   // Inputs are set just after a falling edge; outputs checked before the rising edge.
   task automatic cycle();
      #1 check_outputs();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle();
      we = '0; waddr = '0; wdata = '0; issue_valid = 1'b0; issue_addr = '0; flush = 1'b0;
   endtask

   function automatic vec_t mk(input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [4:0] r0, input logic [4:0] r1,
                               input logic iv, input logic [4:0] ia, input logic fl,
                               input logic [31:0] eb, input logic [31:0] en,
                               input logic [1:0] yb, input logic [1:0] yn, input logic [5:0] c);
      vec_t v;
      v.we = w; v.wa0 = a0; v.wa1 = a1; v.wd0 = d0; v.wd1 = d1; v.ra0 = r0; v.ra1 = r1;
      v.iv = iv; v.ia = ia; v.fl = fl; v.rd0_b = eb; v.rd0_n = en; v.rdy_b = yb; v.rdy_n = yn;
      v.cnt = c;
      return v;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(2'b01, 5, 0, 32'h12345678, 0, 5, 0, 0, 0, 0, 32'h12345678, 0, 2'b11, 2'b11, 0);
      vecs[1]  = mk(2'b00, 0, 0, 0, 0, 5, 0, 0, 0, 0, 32'h12345678, 32'h12345678, 2'b11, 2'b11, 0);
      vecs[2]  = mk(2'b11, 7, 7, 32'hAAAA0000, 32'h0000BBBB, 7, 0, 0, 0, 0, 32'h0000BBBB, 0, 2'b11, 2'b11, 0);
      vecs[3]  = mk(2'b00, 0, 0, 0, 0, 7, 0, 0, 0, 0, 32'h0000BBBB, 32'h0000BBBB, 2'b11, 2'b11, 0);
      vecs[4]  = mk(2'b00, 0, 0, 0, 0, 9, 0, 1, 9, 0, 0, 0, 2'b11, 2'b11, 0);
      vecs[5]  = mk(2'b00, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 1);
      vecs[6]  = mk(2'b01, 9, 0, 32'h55, 0, 9, 0, 0, 0, 0, 32'h55, 0, 2'b11, 2'b10, 1);
      vecs[7]  = mk(2'b00, 0, 0, 0, 0, 9, 0, 0, 0, 0, 32'h55, 32'h55, 2'b11, 2'b11, 0);
      vecs[8]  = mk(2'b00, 0, 0, 0, 0, 3, 0, 1, 3, 0, 0, 0, 2'b11, 2'b11, 0);
      vecs[9]  = mk(2'b10, 0, 3, 0, 32'h33, 3, 0, 1, 3, 0, 32'h33, 0, 2'b11, 2'b10, 1);
      vecs[10] = mk(2'b00, 0, 0, 0, 0, 3, 0, 0, 0, 0, 32'h33, 32'h33, 2'b10, 2'b10, 1);
      vecs[11] = mk(2'b00, 0, 0, 0, 0, 3, 4, 1, 4, 1, 32'h33, 32'h33, 2'b10, 2'b10, 1);
      vecs[12] = mk(2'b00, 0, 0, 0, 0, 3, 4, 0, 0, 0, 32'h33, 32'h33, 2'b11, 2'b11, 0);

      // Reset and read every address.
      model_reset();
      #1 resetn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 32; i++) begin
         raddr = {5'(31 - i), 5'(i)};
         #1;
         check("reset_rdata", rdata_b, 64'd0);
         check("reset_rready", rready_b, 2'b11);
         check("reset_pend_cnt", cnt_b, 6'd0);
         cycle();
      end

      // r0 is read-only zero.
      we = 2'b01; waddr = '0; wdata = {32'd0, 32'hDEADBEEF}; raddr = '0;
      cycle();
      idle();
      #1 check("r0_after_write", rdata_b[31:0], 32'd0);
      cycle();

      // Directed vectors: bypass, port priority, issue/writeback, set-over-clear, flush.
      for (int v = 0; v < 13; v++) begin
         we = vecs[v].we; waddr = {vecs[v].wa1, vecs[v].wa0}; wdata = {vecs[v].wd1, vecs[v].wd0};
         raddr = {vecs[v].ra1, vecs[v].ra0};
         issue_valid = vecs[v].iv; issue_addr = vecs[v].ia; flush = vecs[v].fl;
         #1;
         check($sformatf("vec%0d_byp_rdata0", v), rdata_b[31:0], vecs[v].rd0_b);
         check($sformatf("vec%0d_nob_rdata0", v), rdata_n[31:0], vecs[v].rd0_n);
         check($sformatf("vec%0d_byp_rready", v), rready_b, vecs[v].rdy_b);
         check($sformatf("vec%0d_nob_rready", v), rready_n, vecs[v].rdy_n);
         check($sformatf("vec%0d_pend_cnt", v), cnt_b, vecs[v].cnt);
         cycle();
      end
      idle();

      // Randomised traffic against the model.
      for (int c = 0; c < 400; c++) begin
         we = 2'($urandom);
         for (int i = 0; i < 2; i++) begin
            waddr[i*5 +: 5] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            raddr[i*5 +: 5] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         end
         wdata = {$urandom, $urandom};
         issue_valid = ($urandom_range(0, 2) != 0);
         issue_addr = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         flush = ($urandom_range(0, 39) == 0);
         cycle();
      end
      idle();

      // Fill the scoreboard, then assert reset between clock edges while writes are active.
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      for (int a = 1; a < 32; a++) begin
         issue_valid = 1'b1; issue_addr = 5'(a);
         cycle();
      end
      issue_valid = 1'b0;
      #1 check("pend_cnt_full", cnt_b, 6'd31);
      raddr = {5'd20, 5'd31};
      #1 check("full_rready", rready_b, 2'b00);
      we = 2'b11; waddr = {5'd12, 5'd10}; wdata = {32'hCAFEF00D, 32'h0BADF00D};
      @(negedge clk);
      #2 resetn = 1'b0;
      model_reset();
      #1 check("async_reset_pend_cnt", cnt_b, 6'd0);
      check("async_reset_nob_pend_cnt", cnt_n, 6'd0);
      we = '0;
      for (int i = 0; i < 32; i++) begin
         raddr = {5'(i), 5'(i)};
         #1;
         check("async_reset_rdata", rdata_b, 64'd0);
         check("async_reset_rready", rready_b, 2'b11);
      end
      @(negedge clk);
      resetn = 1'b1;
      idle();
      raddr = {5'd12, 5'd10};
      for (int c = 0; c < 3; c++) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file with an integrated scoreboard. It is the next-generation register file for the pipelined LoongArch core, supporting dual-issue writeback and an operand-ready check.
- Provides NUM_RD combinational read ports and NUM_WR synchronous write ports, with optional same-cycle write-to-read bypass.
- Tracks one pending bit per register: set at issue, cleared at writeback.
- Sits between decode/issue (reads, pending set) and writeback (writes, pending clear).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; NREG = 2**ADDR_W
NUM_RD, 2, number of read ports
NUM_WR, 2, number of write ports
BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads return the stored value only

Ports:
clk  in  1  clock; all state updates on rising edge
resetn  in  1  asynchronous active-low reset
raddr  in  NUM_RD*ADDR_W  read addresses; port k uses slice k
rdata  out  NUM_RD*DATA_W  read data; port k uses slice k
rready  out  NUM_RD  read operand valid (no outstanding producer)
we  in  NUM_WR  write enables, active high
waddr  in  NUM_WR*ADDR_W  write addresses
wdata  in  NUM_WR*DATA_W  write data
issue_valid  in  1  mark a destination register pending
issue_addr  in  ADDR_W  destination register to mark
flush  in  1  synchronous clear of all pending bits
pend_cnt  out  ADDR_W+1  registered count of pending registers

Behaviour:
- Reset (resetn=0, asynchronous): all registers 0, all pending bits 0, pend_cnt=0. Combinational outputs follow: rdata=0 for every address, rready all 1.
- Register 0:
  - Reads of r0 always return 0, with rready=1.
  - Writes to r0 are ignored.
  - issue_valid with issue_addr=0 is ignored.
- Reads are combinational, zero latency. rdata[k] = rf[raddr[k]], except:
  - when BYPASS=1 and some we[i] && waddr[i]==raddr[k] != 0, rdata[k] = wdata of that write port.
  - If several write ports match, the highest index wins.
- Writes occur at the rising edge. If several ports write the same address in one cycle, the highest-index port wins.
- rready[k]:
  - 1 when raddr[k]==0 or pending[raddr[k]]==0.
  - With BYPASS=1, also 1 when a same-cycle write matches raddr[k].
  - issue_valid in the same cycle does not affect rready (the set takes effect next cycle).
- Pending update per edge, in priority order:
  - flush=1: all pending bits go to 0. Same-cycle issue_valid is also discarded; same-cycle writes still update the register array.
  - Otherwise: every we[i] with waddr[i]!=0 clears pending[waddr[i]]. Then issue_valid with issue_addr!=0 sets pending[issue_addr]. Set wins over clear on the same address (new producer).
  - Writing a register whose pending bit is 0 is legal: data is written and pending stays 0.
- pend_cnt:
  - Registered popcount of the pending vector after the edge; updated incrementally with the same priority rules.
  - Range 0..NREG-1; r0 is never counted.
  - Must equal the popcount of the pending vector at all times (bench checks this).
- Reset mid-operation: state clears immediately; no partial write completes.

Decomposition:
- Shared package rf_pkg:
  - constants DATA_W_DEF=32, ADDR_W_DEF=5
  - typedef reg_addr_t (ADDR_W bits)
  - typedef reg_data_t (DATA_W bits)
  - function onehot_priority for write-port selection
- One sub-module, rf_scoreboard:
  - owns the pending vector, flush/set/clear priority and pend_cnt.
  - exposes a pending-bit lookup per read port.
- regfile_mp instantiates rf_scoreboard and contains the array, write arbitration and bypass muxing.

Test Plan:
1. Reset then read all 32 addresses -> rdata=0, rready=1, pend_cnt=0; write r0=0xDEADBEEF, read r0 -> 0.
2. we[0]=1, waddr=5, wdata=0x12345678, same-cycle raddr[0]=5 with BYPASS=1 -> rdata=0x12345678 in that cycle; next cycle, BYPASS=0 build -> old value 0 in the write cycle, 0x12345678 after.
3. Both ports write r7 (port0 0xAAAA0000, port1 0x0000BBBB) -> r7=0x0000BBBB next cycle.
4. issue r9 -> next cycle rready=0 for raddr=9, pend_cnt=1; writeback r9 with 0x55 -> rready=1 (same cycle if BYPASS=1), pend_cnt=0 after the edge.
5. Pending r3, then issue r3 and write r3 in the same cycle -> r3 stays pending, data updated, pend_cnt=1; then flush with issue r4 -> pend_cnt=0, r4 not pending.
6. Issue r1..r31 on consecutive cycles -> pend_cnt=31; assert resetn=0 mid-sequence -> pend_cnt=0 and all registers 0 immediately, without waiting for a clock edge.
